// File: rtl/vlogic_pkg.sv
// Shared types and helpers for the vector-lane bitwise logic sequencer.
package vlogic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_MOVE = 2'b11
    } vlogic_op_e;

    typedef enum logic [1:0] {
        E8  = 2'b00,
        E16 = 2'b01,
        E32 = 2'b10,
        E64 = 2'b11
    } vsew_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } vlogic_state_e;

    // Elements per beat: beat width divided by element width (8 << sew bits).
    function automatic int unsigned calc_epb(vsew_e sew, int unsigned data_width);
        return data_width / (32'd8 << sew);
    endfunction

endpackage

// File: rtl/vlogic_simd.sv
// Per-op SIMD logic units of the lane; each is a plain bitwise function.
module vlogic_and #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    assign y = a & b;
endmodule

module vlogic_or #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    assign y = a | b;
endmodule

module vlogic_xor #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/vlogic_tail_mask.sv
// Builds the bit mask covering the low n active elements of a beat.
module vlogic_tail_mask
    import vlogic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int VL_WIDTH   = 8
) (
    input  logic [VL_WIDTH-1:0]   n,
    input  logic [1:0]            sew,
    output logic [DATA_WIDTH-1:0] mask
);
    logic [31:0] active_bytes;

    // Active bytes = n * SEW/8; each byte below that count is fully enabled.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mask         = '0;
        active_bytes = 32'(n) << sew;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            mask[i*8 +: 8] = (unsigned'(i) < active_bytes) ? 8'hFF : 8'h00;
        end
    end
endmodule

// File: rtl/vlogic_ctrl.sv
// Sequencer streaming one vector logic instruction through the SIMD units
// with tail-undisturbed masking and a registered valid/ready result port.
module vlogic_ctrl
    import vlogic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int VL_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [1:0]            issue_op,
    input  logic [1:0]            issue_sew,
    input  logic [VL_WIDTH-1:0]   issue_vl,
    input  logic                  opnd_valid,
    output logic                  opnd_ready,
    input  logic [DATA_WIDTH-1:0] opnd_1,
    input  logic [DATA_WIDTH-1:0] opnd_2,
    input  logic [DATA_WIDTH-1:0] opnd_old,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_last,
    output logic                  done,
    output logic                  busy
);
    vlogic_state_e         state_q, state_d;
    vlogic_op_e            op_q;
    vsew_e                 sew_q;
    logic [VL_WIDTH-1:0]   rem_q, rem_next, n;
    logic [31:0]           epb;
    logic                  issue_fire, opnd_fire, res_fire, beat_last;
    logic [DATA_WIDTH-1:0] and_y, or_y, xor_y, func_y, mask;

    assign issue_fire = issue_valid && issue_ready;
    assign opnd_fire  = opnd_valid && opnd_ready;
    assign res_fire   = res_valid && res_ready;

    // Active elements this beat never exceed rem, so rem cannot underflow.
    assign epb       = calc_epb(sew_q, unsigned'(DATA_WIDTH));
    assign n         = (32'(rem_q) < epb) ? rem_q : epb[VL_WIDTH-1:0];
    assign rem_next  = rem_q - n;
    assign beat_last = (rem_next == '0);

    vlogic_and #(.DATA_WIDTH(DATA_WIDTH)) u_and (.a(opnd_1), .b(opnd_2), .y(and_y));
    vlogic_or  #(.DATA_WIDTH(DATA_WIDTH)) u_or  (.a(opnd_1), .b(opnd_2), .y(or_y));
    vlogic_xor #(.DATA_WIDTH(DATA_WIDTH)) u_xor (.a(opnd_1), .b(opnd_2), .y(xor_y));

    vlogic_tail_mask #(
        .DATA_WIDTH(DATA_WIDTH),
        .VL_WIDTH  (VL_WIDTH)
    ) u_mask (
        .n   (n),
        .sew (sew_q),
        .mask(mask)
    );

    // Select the SIMD unit output by the latched op; MOVE passes opnd_2.
    always_comb begin
        func_y = opnd_2;
        case (op_q)
            OP_AND:  func_y = and_y;
            OP_OR:   func_y = or_y;
            OP_XOR:  func_y = xor_y;
            default: func_y = opnd_2;
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        issue_ready = 1'b0;
        opnd_ready  = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_fire && issue_vl != '0) state_d = RUN;
            end
            RUN: begin
                opnd_ready = !res_valid || res_ready;
                if (opnd_fire && beat_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (res_fire && res_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Instruction context: op/sew latched at issue, rem counts down per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_AND;
            sew_q <= E8;
            rem_q <= '0;
        end else if (issue_fire) begin
            op_q  <= vlogic_op_e'(issue_op);
            sew_q <= vsew_e'(issue_sew);
            rem_q <= issue_vl;
        end else if (opnd_fire) begin
            rem_q <= rem_next;
        end
    end

    // Result register: loads on operand handshake, holds until drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
        end else if (opnd_fire) begin
            res_valid <= 1'b1;
            res_data  <= (func_y & mask) | (opnd_old & ~mask);
            res_last  <= beat_last;
        end else if (res_fire) begin
            res_valid <= 1'b0;
        end
    end

    // Retire pulse: after the last result drains, or after a vl=0 issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (issue_fire && issue_vl == '0) ||
                            (state_q == DRAIN && res_fire && res_last);
    end

endmodule

// File: tb/tb_vlogic_ctrl.sv
// Directed bench for vlogic_ctrl with hand-computed expected values.
module tb_vlogic_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_op;
    logic [1:0]  issue_sew;
    logic [7:0]  issue_vl;
    logic        opnd_valid;
    logic        opnd_ready;
    logic [63:0] opnd_1, opnd_2, opnd_old;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_last;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    vlogic_ctrl #(.DATA_WIDTH(64), .VL_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_op   (issue_op),
        .issue_sew  (issue_sew),
        .issue_vl   (issue_vl),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .opnd_1     (opnd_1),
        .opnd_2     (opnd_2),
        .opnd_old   (opnd_old),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_last   (res_last),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] and_exp [4];
    int          beats;
    logic [63:0] last_data;
    logic        done_seen;

    initial begin
        and_exp[0] = 64'h1111_0000_1111_0000;
        and_exp[1] = 64'h2222_0000_2222_0000;
        and_exp[2] = 64'h3333_0000_3333_0000;
        and_exp[3] = 64'h4444_0000_4444_0000;

        rst_n = 1'b0; issue_valid = 1'b0; issue_op = 2'b00; issue_sew = 2'b00;
        issue_vl = 8'd0; opnd_valid = 1'b0; opnd_1 = '0; opnd_2 = '0;
        opnd_old = '0; res_ready = 1'b0;

        // Reset values
        #3;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_res_last", 64'(res_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_opnd_ready", 64'(opnd_ready), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // OR, SEW=32, vl=4: two full beats
        issue_valid = 1'b1; issue_op = 2'b01; issue_sew = 2'b10; issue_vl = 8'd4;
        #1 check("or_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        opnd_valid = 1'b1; res_ready = 1'b1;
        opnd_1 = 64'h00FF00FF_0000FFFF; opnd_2 = 64'hFF000000_00FF0000; opnd_old = '0;
        #1;
        check("or_opnd_ready", 64'(opnd_ready), 64'd1);
        check("or_busy", 64'(busy), 64'd1);
        check("or_no_early_valid", 64'(res_valid), 64'd0);
        tick();
        check("or_b1_valid", 64'(res_valid), 64'd1);
        check("or_b1_data", res_data, 64'hFFFF00FF_00FFFFFF);
        check("or_b1_last", 64'(res_last), 64'd0);
        tick();
        opnd_valid = 1'b0;
        #1;
        check("or_b2_valid", 64'(res_valid), 64'd1);
        check("or_b2_data", res_data, 64'hFFFF00FF_00FFFFFF);
        check("or_b2_last", 64'(res_last), 64'd1);
        check("or_drain_opnd_ready", 64'(opnd_ready), 64'd0);
        check("or_no_early_done", 64'(done), 64'd0);
        tick();
        check("or_done", 64'(done), 64'd1);
        check("or_done_issue_ready", 64'(issue_ready), 64'd1);
        check("or_idle_res_valid", 64'(res_valid), 64'd0);
        tick();
        check("or_done_one_cycle", 64'(done), 64'd0);

        // XOR, SEW=8, vl=3: single partial beat, tail keeps old bytes
        issue_valid = 1'b1; issue_op = 2'b10; issue_sew = 2'b00; issue_vl = 8'd3;
        tick();
        issue_valid = 1'b0;
        opnd_valid = 1'b1;
        opnd_1 = 64'hFFFFFFFF_FFFFFFFF; opnd_2 = '0; opnd_old = 64'hAAAAAAAA_AAAAAAAA;
        tick();
        opnd_valid = 1'b0;
        #1;
        check("xor_valid", 64'(res_valid), 64'd1);
        check("xor_data", res_data, 64'hAAAAAAAA_AAFFFFFF);
        check("xor_last", 64'(res_last), 64'd1);
        tick();
        check("xor_done", 64'(done), 64'd1);
        tick();

        // vl=0: no operand traffic, done the cycle after issue
        opnd_valid = 1'b1;
        issue_valid = 1'b1; issue_op = 2'b00; issue_sew = 2'b00; issue_vl = 8'd0;
        #1 check("vl0_opnd_ready_issue", 64'(opnd_ready), 64'd0);
        tick();
        issue_valid = 1'b0;
        #1;
        check("vl0_done", 64'(done), 64'd1);
        check("vl0_issue_ready", 64'(issue_ready), 64'd1);
        check("vl0_opnd_ready", 64'(opnd_ready), 64'd0);
        check("vl0_res_valid", 64'(res_valid), 64'd0);
        check("vl0_busy", 64'(busy), 64'd0);
        tick();
        check("vl0_done_one_cycle", 64'(done), 64'd0);
        opnd_valid = 1'b0;

        // AND, SEW=64, vl=4 with result backpressure after the first beat
        issue_valid = 1'b1; issue_op = 2'b00; issue_sew = 2'b11; issue_vl = 8'd4;
        tick();
        issue_valid = 1'b0;
        res_ready = 1'b0; opnd_valid = 1'b1; opnd_old = '0;
        opnd_2 = 64'hFFFF0000_FFFF0000;
        opnd_1 = 64'h11111111_11111111;
        tick();
        opnd_1 = 64'h22222222_22222222;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("and_stall_valid", 64'(res_valid), 64'd1);
            check("and_stall_data", res_data, and_exp[0]);
            check("and_stall_opnd_ready", 64'(opnd_ready), 64'd0);
            tick();
        end
        res_ready = 1'b1;
        #1 check("and_release_opnd_ready", 64'(opnd_ready), 64'd1);
        tick();
        opnd_1 = 64'h33333333_33333333;
        check("and_b2_data", res_data, and_exp[1]);
        check("and_b2_last", 64'(res_last), 64'd0);
        tick();
        opnd_1 = 64'h44444444_44444444;
        check("and_b3_data", res_data, and_exp[2]);
        check("and_b3_last", 64'(res_last), 64'd0);
        tick();
        opnd_valid = 1'b0;
        check("and_b4_data", res_data, and_exp[3]);
        check("and_b4_last", 64'(res_last), 64'd1);
        tick();
        check("and_done", 64'(done), 64'd1);
        check("and_no_extra_beat", 64'(res_valid), 64'd0);
        tick();

        // Max vl=255, SEW=8: 32 beats, last beat has 7 active bytes
        issue_valid = 1'b1; issue_op = 2'b10; issue_sew = 2'b00; issue_vl = 8'd255;
        tick();
        issue_valid = 1'b0;
        opnd_valid = 1'b1; res_ready = 1'b1;
        opnd_1 = 64'hFFFFFFFF_FFFFFFFF; opnd_2 = '0; opnd_old = '0;
        beats = 0; last_data = '0; done_seen = 1'b0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            tick();
            if (res_valid) begin
                beats++;
                if (res_last) last_data = res_data;
            end
            if (done) done_seen = 1'b1;
        end
        opnd_valid = 1'b0;
        check("vlmax_done_seen", 64'(done_seen), 64'd1);
        check("vlmax_beats", 64'(beats), 64'd32);
        check("vlmax_last_data", last_data, 64'h00FFFFFF_FFFFFFFF);
        tick();

        // Reset mid-instruction after beat 1 of 3
        issue_valid = 1'b1; issue_op = 2'b01; issue_sew = 2'b11; issue_vl = 8'd3;
        tick();
        issue_valid = 1'b0;
        opnd_valid = 1'b1; res_ready = 1'b0;
        opnd_1 = 64'h12345678_9ABCDEF0; opnd_2 = '0;
        tick();
        check("rstmid_b1_valid", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_res_valid", 64'(res_valid), 64'd0);
        check("rstmid_res_data", res_data, 64'd0);
        check("rstmid_res_last", 64'(res_last), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_opnd_ready", 64'(opnd_ready), 64'd0);
        check("rstmid_issue_ready", 64'(issue_ready), 64'd1);
        opnd_valid = 1'b0;
        tick();
        check("rstmid_no_done_a", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rstmid_no_done_b", 64'(done), 64'd0);

        // Fresh MOVE, SEW=8, vl=1 after reset
        issue_valid = 1'b1; issue_op = 2'b11; issue_sew = 2'b00; issue_vl = 8'd1;
        tick();
        issue_valid = 1'b0;
        opnd_valid = 1'b1; res_ready = 1'b1;
        opnd_1 = '0; opnd_2 = 64'h01234567_89ABCDEF; opnd_old = 64'hFEDCBA98_76543210;
        tick();
        opnd_valid = 1'b0;
        #1;
        check("move_valid", 64'(res_valid), 64'd1);
        check("move_data", res_data, 64'hFEDCBA98_765432EF);
        check("move_last", 64'(res_last), 64'd1);
        tick();
        check("move_done", 64'(done), 64'd1);
        check("move_issue_ready", 64'(issue_ready), 64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vlogic_ctrl.md
# vlogic_ctrl

Sequencer for the vector lane's bitwise logic datapath (AND/OR/XOR/MOVE). Accepts one vector logic instruction at a time and streams its operand beats through the SIMD logic function. Applies tail masking so elements past `vl` keep the old destination value (tail-undisturbed). Emits result beats under valid/ready backpressure and pulses `done` when the instruction retires. Sits between the lane issue stage and the lane writeback path.

## Interface
- `DATA_WIDTH`, 64: bits per beat; multiple of 64.
- `VL_WIDTH`, 8: width of the `vl` field (elements).
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: instruction offered.
- `issue_ready` out 1: controller can accept an instruction.
- `issue_op` in 2: 00 AND, 01 OR, 10 XOR, 11 MOVE (result = `opnd_2`).
- `issue_sew` in 2: element width; 00=8, 01=16, 10=32, 11=64 bits.
- `issue_vl` in VL_WIDTH: active element count; 0 allowed.
- `opnd_valid` in 1: operand beat offered.
- `opnd_ready` out 1: operand beat accepted this cycle when both high.
- `opnd_1`, `opnd_2` in DATA_WIDTH: source operands.
- `opnd_old` in DATA_WIDTH: old destination data for tail elements.
- `res_valid` out 1: result beat held in output register.
- `res_ready` in 1: downstream accepts result.
- `res_data` out DATA_WIDTH: result beat.
- `res_last` out 1: high with the final beat of the instruction.
- `done` out 1: one-cycle retire pulse.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `issue_ready`=1. On issue handshake, latch op, sew, `rem` = `issue_vl`. If `vl`≠0, go to RUN. If `vl`=0, stay IDLE and pulse `done` next cycle with no result beats.
- Elements per beat: `epb` = DATA_WIDTH/SEW. Beat count = ceil(vl/epb).
- RUN: `opnd_ready` = !`res_valid` || `res_ready`. On operand handshake:
  - `n` = min(`rem`, `epb`).
  - Byte mask covers the low `n`×SEW/8 bytes.
  - `res_data` = (f(op) & mask) | (`opnd_old` & ~mask).
  - `rem` -= `n`; `res_last` = (`rem` becomes 0). If the beat is last, go to DRAIN.
- DRAIN: `opnd_ready`=0. When the last result handshakes (`res_valid`&&`res_ready`&&`res_last`), go to IDLE and pulse `done` next cycle.
- A new issue is accepted only in IDLE, i.e. no overlap between instructions.
- Issue, operand and result interfaces are valid/ready. Once `res_valid` is asserted, `res_data` and `res_last` stay stable until handshake.
- The upstream operand source supplies `opnd_old` for every beat. Full beats ignore it.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - State = IDLE; `rem`=0.
  - `res_valid`=0, `res_data`=0, `res_last`=0, `done`=0, `busy`=0, `opnd_ready`=0, `issue_ready`=1.
- Reset mid-instruction drops all in-flight beats silently; no `done`.
- Latency: operand handshake at cycle N gives `res_valid` at N+1. Throughput is 1 beat/cycle under continuous `res_ready`.
- Backpressure: while `res_ready`=0 and `res_valid`=1, `opnd_ready`=0. If `res_ready` returns high, a new operand may be accepted in the same cycle the old result drains (no bubble).
- `done` is asserted the cycle after the last result handshake (or after the `vl`=0 issue). `issue_ready` returns to 1 in that same cycle.
- Remaining-count arithmetic is VL_WIDTH bits, unsigned, and never underflows: `n` ≤ `rem`.
- `issue_vl` = 2^VL_WIDTH−1 with SEW=8 and DATA_WIDTH=64 gives 32 beats; the last beat has 7 active bytes.

## Structure
- `vlogic_pkg` holds:
  - `vlogic_op_e` (AND/OR/XOR/MOVE).
  - `vsew_e` (E8/E16/E32/E64).
  - `vlogic_state_e` (IDLE/RUN/DRAIN).
  - A function returning `epb` from SEW and DATA_WIDTH.
- Sub-module `vlogic_tail_mask`: combinational; inputs `n` and sew; output DATA_WIDTH/8 byte-enable expanded to a bit mask.
- The op select uses the lane's existing per-op SIMD logic units, instantiated side by side and muxed by the latched op.

## Test plan
- OR, SEW=32, vl=4, DATA_WIDTH=64, `opnd_1`=0x00FF00FF_0000FFFF, `opnd_2`=0xFF000000_00FF0000, continuous ready:
  - 2 beats, `res_data`=0xFFFF00FF_00FFFFFF each.
  - `res_last` on beat 2; `done` one cycle after.
- XOR, SEW=8, vl=3, `opnd_1`=all 1s, `opnd_2`=0, `opnd_old`=0xAAAAAAAA_AAAAAAAA:
  - Single beat, `res_data`=0xAAAAAAAA_AAFFFFFF, `res_last`=1.
- vl=0 issue:
  - No `opnd_ready`, no `res_valid`.
  - `done` pulses the cycle after the handshake; `issue_ready` stays 1.
- AND, SEW=64, vl=4, `res_ready` held low 3 cycles after the first result:
  - `res_data` is stable throughout and `opnd_ready`=0.
  - On release, all 4 beats arrive in order; no beat is lost or duplicated.
- Assert `rst_n`=0 mid-instruction (after beat 1 of 3):
  - All outputs take their reset values immediately; no `done`.
  - After release, a fresh MOVE with vl=1 completes normally.
